// File: rtl/mem_arbiter.sv
// Shares one slow-memory line port between the I-cache and D-cache miss paths.
// One requester is granted at a time; memory request signals are registered, ready/rdata are routed back combinationally.
module mem_arbiter #(
    parameter int unsigned PRIO_D = 1,
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              mem_read_I,
    input  logic              mem_write_I,
    input  logic [ADDR_W-1:0] mem_addr_I,
    input  logic [DATA_W-1:0] mem_wdata_I,
    output logic [DATA_W-1:0] mem_rdata_I,
    output logic              mem_ready_I,

    input  logic              mem_read_D,
    input  logic              mem_write_D,
    input  logic [ADDR_W-1:0] mem_addr_D,
    input  logic [DATA_W-1:0] mem_wdata_D,
    output logic [DATA_W-1:0] mem_rdata_D,
    output logic              mem_ready_D,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_I   = 2'd1,
        GNT_D   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                last_gnt_d;
    logic                last_gnt_d_nxt;
    logic                read_nxt;
    logic                write_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic                pend_i;
    logic                pend_d;
    logic                pick_d;

    assign pend_i = mem_read_I | mem_write_I;
    assign pend_d = mem_read_D | mem_write_D;

    // D wins when alone, under fixed priority, or on a tie when I was served last.
    assign pick_d = pend_d & (~pend_i | (PRIO_D != 0) | ~last_gnt_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_gnt_d <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            last_gnt_d <= last_gnt_d_nxt;
            mem_read   <= read_nxt;
            mem_write  <= write_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_gnt_d_nxt = last_gnt_d;
        read_nxt       = mem_read;
        write_nxt      = mem_write;
        addr_nxt       = mem_addr;
        wdata_nxt      = mem_wdata;
        mem_ready_I    = 1'b0;
        mem_ready_D    = 1'b0;
        mem_rdata_I    = '0;
        mem_rdata_D    = '0;

        case (state)
            IDLE: begin
                // A combined read+write request is forwarded as a write only.
                if (pick_d) begin
                    state_nxt = GNT_D;
                    addr_nxt  = mem_addr_D;
                    wdata_nxt = mem_wdata_D;
                    write_nxt = mem_write_D;
                    read_nxt  = mem_read_D & ~mem_write_D;
                end else if (pend_i) begin
                    state_nxt = GNT_I;
                    addr_nxt  = mem_addr_I;
                    wdata_nxt = mem_wdata_I;
                    write_nxt = mem_write_I;
                    read_nxt  = mem_read_I & ~mem_write_I;
                end
            end
            GNT_I: begin
                mem_ready_I = mem_ready;
                mem_rdata_I = mem_rdata;
                if (mem_ready) begin
                    read_nxt       = 1'b0;
                    write_nxt      = 1'b0;
                    last_gnt_d_nxt = 1'b0;
                    state_nxt      = RELEASE;
                end
            end
            GNT_D: begin
                mem_ready_D = mem_ready;
                mem_rdata_D = mem_rdata;
                if (mem_ready) begin
                    read_nxt       = 1'b0;
                    write_nxt      = 1'b0;
                    last_gnt_d_nxt = 1'b1;
                    state_nxt      = RELEASE;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fixed-priority instance plus a round-robin instance sharing stimulus.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 128;

    logic              clk;
    logic              rst;
    logic              mem_read_I;
    logic              mem_write_I;
    logic [ADDR_W-1:0] mem_addr_I;
    logic [DATA_W-1:0] mem_wdata_I;
    logic              mem_read_D;
    logic              mem_write_D;
    logic [ADDR_W-1:0] mem_addr_D;
    logic [DATA_W-1:0] mem_wdata_D;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic [DATA_W-1:0] mem_rdata_I;
    logic              mem_ready_I;
    logic [DATA_W-1:0] mem_rdata_D;
    logic              mem_ready_D;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] rr_rdata_I;
    logic              rr_ready_I;
    logic [DATA_W-1:0] rr_rdata_D;
    logic              rr_ready_D;
    logic              rr_read;
    logic              rr_write;
    logic [ADDR_W-1:0] rr_addr;
    logic [DATA_W-1:0] rr_wdata;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.PRIO_D(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .mem_read_I(mem_read_I), .mem_write_I(mem_write_I), .mem_addr_I(mem_addr_I),
        .mem_wdata_I(mem_wdata_I), .mem_rdata_I(mem_rdata_I), .mem_ready_I(mem_ready_I),
        .mem_read_D(mem_read_D), .mem_write_D(mem_write_D), .mem_addr_D(mem_addr_D),
        .mem_wdata_D(mem_wdata_D), .mem_rdata_D(mem_rdata_D), .mem_ready_D(mem_ready_D),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_arbiter #(.PRIO_D(0), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut_rr (
        .clk(clk), .rst(rst),
        .mem_read_I(mem_read_I), .mem_write_I(mem_write_I), .mem_addr_I(mem_addr_I),
        .mem_wdata_I(mem_wdata_I), .mem_rdata_I(rr_rdata_I), .mem_ready_I(rr_ready_I),
        .mem_read_D(mem_read_D), .mem_write_D(mem_write_D), .mem_addr_D(mem_addr_D),
        .mem_wdata_D(mem_wdata_D), .mem_rdata_D(rr_rdata_D), .mem_ready_D(rr_ready_D),
        .mem_read(rr_read), .mem_write(rr_write), .mem_addr(rr_addr),
        .mem_wdata(rr_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_read: got %b want 0", mem_read); end
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_write: got %b want 0", mem_write); end
        total++; if (mem_addr !== 28'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        total++; if (mem_wdata !== 128'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        total++; if ({mem_ready_I, mem_ready_D} !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", {mem_ready_I, mem_ready_D}); end
        rst = 1'b0;
    endtask

    task automatic test_single_i_read();
        mem_read_I = 1'b1;
        mem_addr_I = 28'h0000010;
        step();
        total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL single_read: got %b want 1", mem_read); end
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL single_write: got %b want 0", mem_write); end
        total++; if (mem_addr !== 28'h0000010) begin bad++; $display("FAIL single_addr: got %h want 0000010", mem_addr); end
        mem_ready = 1'b1;
        mem_rdata = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        #1;
        total++; if (mem_ready_I !== 1'b1) begin bad++; $display("FAIL single_ready_I: got %b want 1", mem_ready_I); end
        total++; if (mem_rdata_I !== 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210) begin bad++; $display("FAIL single_rdata_I: got %h want 0123456789abcdeffedcba9876543210", mem_rdata_I); end
        total++; if (mem_ready_D !== 1'b0) begin bad++; $display("FAIL single_ready_D: got %b want 0", mem_ready_D); end
        total++; if (mem_rdata_D !== 128'h0) begin bad++; $display("FAIL single_rdata_D: got %h want 0", mem_rdata_D); end
        step();
        mem_ready  = 1'b0;
        mem_read_I = 1'b0;
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL single_release_read: got %b want 0", mem_read); end
        step();
    endtask

    task automatic test_priority();
        mem_read_I  = 1'b1;
        mem_addr_I  = 28'h0000030;
        mem_write_D = 1'b1;
        mem_addr_D  = 28'h0000040;
        mem_wdata_D = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
        step();
        total++; if ({mem_write, mem_read} !== 2'b10) begin bad++; $display("FAIL prio_first_op: got %b want 10", {mem_write, mem_read}); end
        total++; if (mem_addr !== 28'h0000040) begin bad++; $display("FAIL prio_first_addr: got %h want 0000040", mem_addr); end
        total++; if (mem_wdata !== 128'hdead_beef_0000_1111_2222_3333_4444_5555) begin bad++; $display("FAIL prio_wdata: got %h want deadbeef000011112222333344445555", mem_wdata); end
        mem_ready = 1'b1;
        mem_rdata = 128'h55;
        #1;
        total++; if ({mem_ready_D, mem_ready_I} !== 2'b10) begin bad++; $display("FAIL prio_first_ready: got %b want 10", {mem_ready_D, mem_ready_I}); end
        step();
        mem_ready   = 1'b0;
        mem_write_D = 1'b0;
        total++; if ({mem_write, mem_read} !== 2'b00) begin bad++; $display("FAIL prio_release: got %b want 00", {mem_write, mem_read}); end
        step();
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL prio_idle_gap: got %b want 0", mem_read); end
        step();
        total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL prio_second_read: got %b want 1", mem_read); end
        total++; if (mem_addr !== 28'h0000030) begin bad++; $display("FAIL prio_second_addr: got %h want 0000030", mem_addr); end
        mem_ready = 1'b1;
        mem_rdata = 128'h77;
        #1;
        total++; if ({mem_ready_D, mem_ready_I} !== 2'b01) begin bad++; $display("FAIL prio_second_ready: got %b want 01", {mem_ready_D, mem_ready_I}); end
        total++; if (mem_rdata_I !== 128'h77) begin bad++; $display("FAIL prio_second_rdata: got %h want 77", mem_rdata_I); end
        step();
        mem_ready  = 1'b0;
        mem_read_I = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        logic [ADDR_W-1:0] exp_addr [4];
        logic [1:0]        exp_rdy  [4];
        exp_addr[0] = 28'h0000060; exp_rdy[0] = 2'b10;
        exp_addr[1] = 28'h0000050; exp_rdy[1] = 2'b01;
        exp_addr[2] = 28'h0000060; exp_rdy[2] = 2'b10;
        exp_addr[3] = 28'h0000050; exp_rdy[3] = 2'b01;
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_read_I = 1'b1;
        mem_addr_I = 28'h0000050;
        mem_read_D = 1'b1;
        mem_addr_D = 28'h0000060;
        for (int t = 0; t < 4; t++) begin
            step();
            total++; if (rr_read !== 1'b1 || rr_addr !== exp_addr[t]) begin bad++; $display("FAIL rr_grant%0d: got read=%b addr=%h want read=1 addr=%h", t, rr_read, rr_addr, exp_addr[t]); end
            mem_ready = 1'b1;
            #1;
            total++; if ({rr_ready_D, rr_ready_I} !== exp_rdy[t]) begin bad++; $display("FAIL rr_ready%0d: got %b want %b", t, {rr_ready_D, rr_ready_I}, exp_rdy[t]); end
            step();
            mem_ready = 1'b0;
            step();
        end
        mem_read_I = 1'b0;
        mem_read_D = 1'b0;
        step();
        step();
    endtask

    task automatic test_rw_both();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_read_D  = 1'b1;
        mem_write_D = 1'b1;
        mem_addr_D  = 28'h0000020;
        mem_wdata_D = 128'habc;
        step();
        total++; if ({mem_write, mem_read} !== 2'b10) begin bad++; $display("FAIL rw_op: got %b want 10", {mem_write, mem_read}); end
        total++; if (mem_addr !== 28'h0000020) begin bad++; $display("FAIL rw_addr: got %h want 0000020", mem_addr); end
        mem_ready = 1'b1;
        step();
        mem_ready   = 1'b0;
        mem_read_D  = 1'b0;
        mem_write_D = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        mem_read_I = 1'b1;
        mem_addr_I = 28'h0000070;
        step();
        total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL midrst_pre_read: got %b want 1", mem_read); end
        rst        = 1'b1;
        mem_read_I = 1'b0;
        step();
        total++; if (mem_read !== 1'b0 || mem_addr !== 28'h0) begin bad++; $display("FAIL midrst_outputs: got read=%b addr=%h want read=0 addr=0", mem_read, mem_addr); end
        rst       = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 128'h99;
        #1;
        total++; if ({mem_ready_I, mem_ready_D} !== 2'b00) begin bad++; $display("FAIL midrst_ready: got %b want 00", {mem_ready_I, mem_ready_D}); end
        total++; if (mem_rdata_I !== 128'h0) begin bad++; $display("FAIL midrst_rdata: got %h want 0", mem_rdata_I); end
        step();
        mem_ready = 1'b0;
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL midrst_idle: got %b want 0", mem_read); end
        step();
    endtask

    task automatic test_spurious_ready();
        mem_ready = 1'b1;
        mem_rdata = 128'h1234;
        #1;
        total++; if ({mem_ready_I, mem_ready_D} !== 2'b00) begin bad++; $display("FAIL spur_ready: got %b want 00", {mem_ready_I, mem_ready_D}); end
        total++; if ({mem_rdata_I, mem_rdata_D} !== 256'h0) begin bad++; $display("FAIL spur_rdata: got %h want 0", {mem_rdata_I, mem_rdata_D}); end
        step();
        total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL spur_no_req: got %b want 00", {mem_read, mem_write}); end
        mem_ready = 1'b0;
        step();
    endtask

    initial begin
        rst         = 1'b1;
        mem_read_I  = 1'b0;
        mem_write_I = 1'b0;
        mem_addr_I  = '0;
        mem_wdata_I = '0;
        mem_read_D  = 1'b0;
        mem_write_D = 1'b0;
        mem_addr_D  = '0;
        mem_wdata_D = '0;
        mem_rdata   = '0;
        mem_ready   = 1'b0;

        test_reset();
        test_single_i_read();
        test_priority();
        test_round_robin();
        test_rw_both();
        test_reset_mid();
        test_spurious_ready();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
